// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the fetch/decode decoupling queue.
package fetch_queue_pkg;

  localparam int unsigned FQ_DEPTH = 16;
  localparam int unsigned FQ_PTR_W = $clog2(FQ_DEPTH);
  localparam int unsigned FQ_LANES = 4;

  typedef logic [FQ_PTR_W-1:0] FQ_PTR;
  typedef logic [FQ_PTR_W:0]   FQ_CNT;

  // One fetched instruction handed to decode.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } DECODE_REQUIRE;

  // Lane counts above 4 are illegal; hardware treats them as 4.
  function automatic logic [2:0] fq_clamp4(input logic [2:0] n);
    return (n > 3'd4) ? 3'd4 : n;
  endfunction

endpackage

// File: rtl/fetch_queue_lane_rotate.sv
// Lane rotation between the 4-wide fetch/decode interfaces and circular storage.
module fq_lane_rotate
  import fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = FQ_DEPTH,
  parameter int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic [PTR_W-1:0]       wr_ptr,
  input  logic [PTR_W-1:0]       rd_ptr,
  input  logic [2:0]             wr_num,
  input  DECODE_REQUIRE [3:0]    in_lanes,
  input  DECODE_REQUIRE          mem [DEPTH],
  output logic [DEPTH-1:0]       wr_en,
  output DECODE_REQUIRE          wr_data [DEPTH],
  output DECODE_REQUIRE [3:0]    out_lanes
);

  // Each storage slot picks the input lane at its distance from wr_ptr.
  always_comb begin
    logic [PTR_W-1:0] offset;
    offset = '0;
    for (int unsigned j = 0; j < DEPTH; j++) begin
      offset     = PTR_W'(j) - wr_ptr;
      wr_en[j]   = (offset < PTR_W'(wr_num));
      wr_data[j] = in_lanes[offset[1:0]];
    end
  end

  // Oldest four entries starting at rd_ptr, wrapping modulo DEPTH.
  always_comb begin
    for (int unsigned i = 0; i < 4; i++) begin
      out_lanes[i] = mem[rd_ptr + PTR_W'(i)];
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// Circular instruction buffer decoupling fetch from decode.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = FQ_DEPTH,
  parameter int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flash,
  input  logic [2:0]          push_num,
  input  DECODE_REQUIRE [3:0] push_data,
  input  logic [2:0]          pop_num,
  output DECODE_REQUIRE [3:0] out_data,
  output logic [2:0]          out_num,
  output logic [PTR_W:0]      free_num,
  output logic                stall_from_fetchq
);

  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W:0]   count;
  DECODE_REQUIRE    mem [DEPTH];
  logic [DEPTH-1:0] wr_en;
  DECODE_REQUIRE    wr_data [DEPTH];
  logic [2:0]       push_c;
  logic [2:0]       pop_c;
  logic [2:0]       acc_push;
  logic [2:0]       eff_pop;
  logic             accept;

  fq_lane_rotate #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_rotate (
    .wr_ptr    (wr_ptr),
    .rd_ptr    (rd_ptr),
    .wr_num    (acc_push),
    .in_lanes  (push_data),
    .mem       (mem),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .out_lanes (out_data)
  );

  // Occupancy flags and the accepted push / effective pop for this cycle.
  // Push room is judged on registered occupancy only; a same-cycle pop never helps.
  always_comb begin
    push_c            = fq_clamp4(push_num);
    pop_c             = fq_clamp4(pop_num);
    out_num           = (count >= (PTR_W+1)'(4)) ? 3'd4 : count[2:0];
    free_num          = (PTR_W+1)'(DEPTH) - count;
    accept            = ((PTR_W+1)'(push_c) <= free_num);
    stall_from_fetchq = ~accept & ~flash;
    acc_push          = (accept && !flash) ? push_c : 3'd0;
    eff_pop           = flash ? 3'd0 : ((pop_c < out_num) ? pop_c : out_num);
  end

  // Pointer and occupancy update; flash clears everything below reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flash) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PTR_W'(acc_push);
      rd_ptr <= rd_ptr + PTR_W'(eff_pop);
      count  <= count + (PTR_W+1)'(acc_push) - (PTR_W+1)'(eff_pop);
    end
  end

  // Entry storage, not reset; only slots covered by an accepted push are written.
  always_ff @(posedge clk) begin
    for (int unsigned j = 0; j < DEPTH; j++) begin
      if (wr_en[j]) mem[j] <= wr_data[j];
    end
  end

  // Lane counts above four are illegal from fetch and decode.
  a_push_legal: assert property (@(posedge clk) disable iff (!rst_n) push_num <= 3'd4);
  a_pop_legal:  assert property (@(posedge clk) disable iff (!rst_n) pop_num <= 3'd4);

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue against a queue-based reference model.
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  localparam int DEPTH = 16;

  logic                clk;
  logic                rst_n;
  logic                flash;
  logic [2:0]          push_num;
  DECODE_REQUIRE [3:0] push_data;
  logic [2:0]          pop_num;
  DECODE_REQUIRE [3:0] out_data;
  logic [2:0]          out_num;
  logic [4:0]          free_num;
  logic                stall_from_fetchq;

  int checks = 0;
  int errors = 0;

  DECODE_REQUIRE q[$];
  logic [31:0]   next_pc;
  logic          exp_stall;
  logic          obs_stall;

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .flash             (flash),
    .push_num          (push_num),
    .push_data         (push_data),
    .pop_num           (pop_num),
    .out_data          (out_data),
    .out_num           (out_num),
    .free_num          (free_num),
    .stall_from_fetchq (stall_from_fetchq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock: drive at negedge, capture stall, update model at posedge.
  task automatic cycle(input int pn, input int pp, input bit fl, input bit rn);
    int free_m;
    int eff;
    @(negedge clk);
    rst_n    = rn;
    flash    = fl;
    push_num = 3'(pn);
    pop_num  = 3'(pp);
    for (int i = 0; i < 4; i++) begin
      push_data[i].pc   = next_pc + 32'(4 * i);
      push_data[i].inst = $urandom;
    end
    #1;
    free_m    = DEPTH - q.size();
    exp_stall = (pn > free_m) && !fl;
    obs_stall = stall_from_fetchq;
    @(posedge clk);
    if (!rn || fl) begin
      q.delete();
    end else begin
      eff = (pp < q.size()) ? pp : q.size();
      for (int i = 0; i < eff; i++) void'(q.pop_front());
      if (pn <= free_m) begin
        for (int i = 0; i < pn; i++) q.push_back(push_data[i]);
        next_pc = next_pc + 32'(4 * pn);
      end
    end
    #1;
  endtask

  task automatic test_reset();
    next_pc = 32'h0;
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 1);
    checks++; if (out_num !== 3'd0) begin errors++; $display("FAIL reset_out_num got %0d exp 0", out_num); end
    checks++; if (free_num !== 5'd16) begin errors++; $display("FAIL reset_free_num got %0d exp 16", free_num); end
    checks++; if (obs_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %0b exp 0", obs_stall); end
  endtask

  task automatic test_fill();
    for (int c = 0; c < 3; c++) cycle(4, 0, 0, 1);
    checks++; if (free_num !== 5'd4) begin errors++; $display("FAIL fill_free got %0d exp 4", free_num); end
    checks++; if (out_num !== 3'd4) begin errors++; $display("FAIL fill_out_num got %0d exp 4", out_num); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_data[i].pc !== 32'(4 * i)) begin
        errors++; $display("FAIL fill_lane%0d_pc got %h exp %h", i, out_data[i].pc, 32'(4 * i));
      end
    end
  endtask

  task automatic test_push_pop();
    cycle(4, 2, 0, 1);
    checks++; if (obs_stall !== 1'b0) begin errors++; $display("FAIL pushpop_stall got %0b exp 0", obs_stall); end
    checks++; if (free_num !== 5'd2) begin errors++; $display("FAIL pushpop_free got %0d exp 2", free_num); end
    checks++; if (out_data[0].pc !== 32'h08) begin errors++; $display("FAIL pushpop_lane0 got %h exp 08", out_data[0].pc); end
  endtask

  task automatic test_stall();
    cycle(3, 4, 0, 1);
    checks++; if (obs_stall !== 1'b1) begin errors++; $display("FAIL stall_flag got %0b exp 1", obs_stall); end
    checks++; if (free_num !== 5'd6) begin errors++; $display("FAIL stall_free got %0d exp 6", free_num); end
    checks++; if (out_data[0].pc !== 32'h18) begin errors++; $display("FAIL stall_lane0 got %h exp 18", out_data[0].pc); end
    checks++; if (next_pc !== 32'h40) begin errors++; $display("FAIL stall_pc_hold got %h exp 40", next_pc); end
  endtask

  task automatic test_wrap();
    for (int c = 0; c < 20; c++) begin
      cycle(2, 2, 0, 1);
      checks++;
      if (free_num !== 5'd6) begin errors++; $display("FAIL wrap_free c%0d got %0d exp 6", c, free_num); end
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (out_data[i] !== q[i] || out_data[i].pc !== out_data[0].pc + 32'(4 * i)) begin
          errors++; $display("FAIL wrap_lane%0d c%0d got %h exp %h", i, c, out_data[i], q[i]);
        end
      end
    end
  endtask

  task automatic test_flash();
    cycle(0, 1, 0, 1);
    checks++; if (free_num !== 5'd7) begin errors++; $display("FAIL flash_pre_free got %0d exp 7", free_num); end
    cycle(4, 3, 1, 1);
    checks++; if (obs_stall !== 1'b0) begin errors++; $display("FAIL flash_stall got %0b exp 0", obs_stall); end
    checks++; if (out_num !== 3'd0) begin errors++; $display("FAIL flash_out_num got %0d exp 0", out_num); end
    checks++; if (free_num !== 5'd16) begin errors++; $display("FAIL flash_free got %0d exp 16", free_num); end
    #3;
    checks++; if (stall_from_fetchq !== 1'b0) begin errors++; $display("FAIL flash_stall_after got %0b exp 0", stall_from_fetchq); end
  endtask

  task automatic test_underflow_reset();
    cycle(1, 0, 0, 1);
    checks++; if (out_num !== 3'd1) begin errors++; $display("FAIL uf_out_num got %0d exp 1", out_num); end
    checks++; if (out_data[0] !== q[0]) begin errors++; $display("FAIL uf_lane0 got %h exp %h", out_data[0], q[0]); end
    cycle(0, 4, 0, 1);
    checks++; if (out_num !== 3'd0) begin errors++; $display("FAIL uf_empty got %0d exp 0", out_num); end
    checks++; if (free_num !== 5'd16) begin errors++; $display("FAIL uf_free got %0d exp 16", free_num); end
    cycle(4, 0, 0, 1);
    cycle(4, 1, 0, 1);
    checks++; if (free_num !== 5'd9) begin errors++; $display("FAIL pre_rst_free got %0d exp 9", free_num); end
    cycle(4, 0, 0, 0);
    checks++; if (free_num !== 5'd16) begin errors++; $display("FAIL rst_free got %0d exp 16", free_num); end
    checks++; if (out_num !== 3'd0) begin errors++; $display("FAIL rst_out_num got %0d exp 0", out_num); end
  endtask

  task automatic test_random();
    int pn, pp;
    bit fl;
    int exp_num;
    for (int c = 0; c < 400; c++) begin
      pn = $urandom_range(0, 4);
      pp = (c % 100 < 50) ? $urandom_range(0, 1) : $urandom_range(0, 4);
      fl = ($urandom_range(0, 39) == 0);
      cycle(pn, pp, fl, 1);
      exp_num = (q.size() < 4) ? q.size() : 4;
      checks++;
      if (obs_stall !== exp_stall) begin errors++; $display("FAIL rnd_stall c%0d got %0b exp %0b", c, obs_stall, exp_stall); end
      checks++;
      if (out_num !== 3'(exp_num)) begin errors++; $display("FAIL rnd_out_num c%0d got %0d exp %0d", c, out_num, exp_num); end
      checks++;
      if (free_num !== 5'(DEPTH - q.size())) begin
        errors++; $display("FAIL rnd_free c%0d got %0d exp %0d", c, free_num, DEPTH - q.size());
      end
      for (int i = 0; i < exp_num; i++) begin
        checks++;
        if (out_data[i] !== q[i]) begin errors++; $display("FAIL rnd_lane%0d c%0d got %h exp %h", i, c, out_data[i], q[i]); end
      end
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    flash     = 1'b0;
    push_num  = '0;
    pop_num   = '0;
    push_data = '0;
    test_reset();
    test_fill();
    test_push_pop();
    test_stall();
    test_wrap();
    test_flash();
    test_underflow_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
